mem_port_arbiter: RTL

- Shares the single backing-memory port (the LSU line interface) between the I-cache and D-cache miss/write-back FSMs.
- Each cache presents a line request (addr, line data, rw, valid) and holds it until it sees ready.
- The arbiter grants one requester at a time, registers the granted request onto the memory port, and routes the memory ready/data back to the owner.
- Also provides a per-transaction watchdog and a busy/owner status for stall logic.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_arb_watchdog.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared cache types for the memory port arbiter.
// FSM state codes, owner encodings and the default line geometry.
package mem_port_arbiter_pkg;

    localparam int unsigned LINE_W_DEF = 128;
    localparam int unsigned ADDR_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] mem_addr_t;
    typedef logic [LINE_W_DEF-1:0] mem_line_t;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_BUSY = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IC   = 2'b01;
    localparam logic [1:0] OWN_DC   = 2'b10;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: per-transaction cycle counter with a sticky
// timeout flag; expire_o fires on the last allowed BUSY cycle.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic busy_i,
    input  logic done_i,
    output logic expire_o,
    output logic timeout_o
);

    localparam int unsigned CLOG = $clog2(TIMEOUT_CYC);
    localparam int unsigned CNT_W = (CLOG > 10) ? CLOG : 10;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // A completion in the final cycle beats the timeout.
    assign expire_o = busy_i && (cnt_q == LIMIT) && !done_i;

    // Count BUSY cycles from the grant; latch any expiry until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (start_i) begin
                cnt_q <= '0;
            end else if (busy_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (expire_o) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the line memory port between I$ and D$.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin, else D$ has priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_valid_i,
    input  logic              ic_req_rw_i,
    input  logic [ADDR_W-1:0] ic_req_addr_i,
    input  logic [LINE_W-1:0] ic_req_data_i,
    output logic              ic_resp_ready_o,
    output logic [LINE_W-1:0] ic_resp_data_o,
    input  logic              dc_req_valid_i,
    input  logic              dc_req_rw_i,
    input  logic [ADDR_W-1:0] dc_req_addr_i,
    input  logic [LINE_W-1:0] dc_req_data_i,
    output logic              dc_resp_ready_o,
    output logic [LINE_W-1:0] dc_resp_data_o,
    output logic              mem_req_valid_o,
    output logic              mem_req_rw_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [LINE_W-1:0] mem_req_data_o,
    input  logic              mem_resp_ready_i,
    input  logic [LINE_W-1:0] mem_resp_data_i,
    output logic              busy_o,
    output logic [1:0]        owner_o,
    output logic              timeout_o
);

    logic              state_q;
    logic [1:0]        owner_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;

    logic any_req;
    logic grant_ic;
    logic grant_dc;
    logic start;
    logic done;
    logic expire;

    assign any_req = ic_req_valid_i | dc_req_valid_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_q;

    // rr_q=0 favours the I$, rr_q=1 favours the D$.
    assign grant_ic = ic_req_valid_i & (~dc_req_valid_i | ~rr_q);
    assign grant_dc = dc_req_valid_i & ~grant_ic;

    // Hand priority to whoever was not just served.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else if (done) begin
            rr_q <= (owner_q == OWN_IC);
        end
    end
`else
    assign grant_dc = dc_req_valid_i;
    assign grant_ic = ic_req_valid_i & ~dc_req_valid_i;
`endif

    assign start = (state_q == ARB_IDLE) & any_req;
    assign done  = (state_q == ARB_BUSY) & mem_resp_ready_i;

    // Grant in IDLE, hold the registered request until done or expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        state_q <= ARB_BUSY;
                        owner_q <= grant_dc ? OWN_DC : OWN_IC;
                        rw_q    <= grant_dc ? dc_req_rw_i : ic_req_rw_i;
                        addr_q  <= grant_dc ? dc_req_addr_i : ic_req_addr_i;
                        data_q  <= grant_dc ? dc_req_data_i : ic_req_data_i;
                    end
                end
                ARB_BUSY: begin
                    if (done || expire) begin
                        state_q <= ARB_IDLE;
                        owner_q <= OWN_NONE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start),
        .busy_i    (state_q == ARB_BUSY),
        .done_i    (mem_resp_ready_i),
        .expire_o  (expire),
        .timeout_o (timeout_o)
    );

    assign mem_req_valid_o = (state_q == ARB_BUSY);
    assign mem_req_rw_o    = rw_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_data_o  = data_q;

    assign ic_resp_ready_o = done & (owner_q == OWN_IC);
    assign dc_resp_ready_o = done & (owner_q == OWN_DC);
    assign ic_resp_data_o  = mem_resp_data_i;
    assign dc_resp_data_o  = mem_resp_data_i;

    assign busy_o  = (state_q == ARB_BUSY);
    assign owner_o = owner_q;

endmodule
